pi2bpsk_demapper: RTL and testbench

//  Soft demapper for pi/2-BPSK PUCCH/PUSCH symbols: receive-side inverse of the pi/2-BPSK mapper.

---
 rtl/pi2bpsk_demapper.sv | 132 +++++++++++++
 tb/tb_pi2bpsk_demapper.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi2bpsk_demapper.sv
// pi/2-BPSK soft demapper: derotates equalised Q1.15 symbols by symbol-index parity and
// emits a saturated signed LLR, hard bit and block index through a 2-stage valid/ready pipeline.
module pi2bpsk_demapper #(
  parameter int LLR_W     = 8,
  parameter int LLR_SHIFT = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sop,
  input  logic             i_last,
  input  logic [15:0]      i_re,
  input  logic [15:0]      i_im,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LLR_W-1:0] o_llr,
  output logic             o_bit,
  output logic [15:0]      o_index,
  output logic             o_sop,
  output logic             o_last
);

  // Symmetric clamp: the most-negative two's complement code is never emitted.
  localparam int                 LLR_MAX_I = (1 << (LLR_W - 1)) - 1;
  localparam logic signed [16:0] LLR_MAX   = 17'(LLR_MAX_I);
  localparam logic signed [16:0] LLR_MIN   = -LLR_MAX;

  logic                    s1_valid_reg;
  logic signed [16:0]      s1_metric_reg;
  logic [15:0]             s1_index_reg;
  logic                    s1_sop_reg;
  logic                    s1_last_reg;

  logic                    s2_valid_reg;
  logic [LLR_W-1:0]        s2_llr_reg;
  logic                    s2_bit_reg;
  logic [15:0]             s2_index_reg;
  logic                    s2_sop_reg;
  logic                    s2_last_reg;

  logic [15:0]             idx_reg;
  logic [15:0]             idx_next;
  logic [15:0]             sym_k;
  logic                    s2_load;
  logic                    s1_load;
  logic                    accept;
  logic signed [16:0]      re_ext;
  logic signed [16:0]      im_ext;
  logic signed [16:0]      metric_next;
  logic signed [16:0]      shifted;
  logic [LLR_W-1:0]        llr_sat;

  always_comb begin
    s2_load = !s2_valid_reg || i_ready;
    s1_load = !s1_valid_reg || s2_load;
    o_ready = s1_load;
    accept  = i_valid && s1_load;

    // A start-of-block symbol is always index 0 regardless of the running count.
    sym_k    = i_sop ? 16'd0 : idx_reg;
    idx_next = idx_reg;
    if (accept) begin
      idx_next = i_last ? 16'd0 : sym_k + 16'd1;
    end

    re_ext      = {i_re[15], i_re};
    im_ext      = {i_im[15], i_im};
    metric_next = sym_k[0] ? (im_ext - re_ext) : (re_ext + im_ext);
  end

  always_comb begin
    shifted = s1_metric_reg >>> LLR_SHIFT;
    if (shifted > LLR_MAX) begin
      llr_sat = LLR_MAX[LLR_W-1:0];
    end else if (shifted < LLR_MIN) begin
      llr_sat = LLR_MIN[LLR_W-1:0];
    end else begin
      llr_sat = shifted[LLR_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_reg       <= '0;
      s1_valid_reg  <= 1'b0;
      s1_metric_reg <= '0;
      s1_index_reg  <= '0;
      s1_sop_reg    <= 1'b0;
      s1_last_reg   <= 1'b0;
    end else begin
      idx_reg <= idx_next;
      if (s1_load) begin
        s1_valid_reg <= i_valid;
      end
      if (accept) begin
        s1_metric_reg <= metric_next;
        s1_index_reg  <= sym_k;
        s1_sop_reg    <= i_sop;
        s1_last_reg   <= i_last;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_llr_reg   <= '0;
      s2_bit_reg   <= 1'b0;
      s2_index_reg <= '0;
      s2_sop_reg   <= 1'b0;
      s2_last_reg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_llr_reg   <= llr_sat;
        s2_bit_reg   <= s1_metric_reg[16];
        s2_index_reg <= s1_index_reg;
        s2_sop_reg   <= s1_sop_reg;
        s2_last_reg  <= s1_last_reg;
      end
    end
  end

  assign o_valid = s2_valid_reg;
  assign o_llr   = s2_llr_reg;
  assign o_bit   = s2_bit_reg;
  assign o_index = s2_index_reg;
  assign o_sop   = s2_sop_reg;
  assign o_last  = s2_last_reg;

endmodule

// File: tb/tb_pi2bpsk_demapper.sv
// Scoreboard bench for pi2bpsk_demapper: two instances (default shift, and shift 0 for saturation)
// share one input stream; a reference model fills a queue that a monitor drains and compares.
module tb_pi2bpsk_demapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_sop, i_last, i_ready;
  logic [15:0] re, im;

  logic        o_ready_a, o_valid_a, o_bit_a, o_sop_a, o_last_a;
  logic [7:0]  o_llr_a;
  logic [15:0] o_index_a;
  logic        o_ready_b, o_valid_b, o_bit_b, o_sop_b, o_last_b;
  logic [7:0]  o_llr_b;
  logic [15:0] o_index_b;

  always #5 clk = ~clk;

  pi2bpsk_demapper #(.LLR_W(8), .LLR_SHIFT(10)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_sop(i_sop), .i_last(i_last), .i_re(re), .i_im(im),
    .o_valid(o_valid_a), .i_ready(i_ready), .o_llr(o_llr_a), .o_bit(o_bit_a),
    .o_index(o_index_a), .o_sop(o_sop_a), .o_last(o_last_a));

  pi2bpsk_demapper #(.LLR_W(8), .LLR_SHIFT(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_sop(i_sop), .i_last(i_last), .i_re(re), .i_im(im),
    .o_valid(o_valid_b), .i_ready(i_ready), .o_llr(o_llr_b), .o_bit(o_bit_b),
    .o_index(o_index_b), .o_sop(o_sop_b), .o_last(o_last_b));

  typedef struct {
    int llr_a;
    int llr_b;
    int bit_v;
    int index;
    int sop;
    int last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   in_flight = 0;
  int   cyc = 0;
  int   mdl_idx = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random 50%, 2: held low
  int   acc_cyc = 0;
  bit   stalled = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_llr(input int m, input int sh, input int w);
    int v, mx;
    v  = m >>> sh;
    mx = (1 << (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx) return -mx;
    return v;
  endfunction

  // Reference: derotate by index parity, then shift and clamp; index restarts on sop and after last.
  function automatic exp_t model(input logic [15:0] re_v, input logic [15:0] im_v,
                                 input bit sop, input bit last);
    exp_t e;
    int k, r, m_i, m;
    k   = sop ? 0 : mdl_idx;
    r   = $signed(re_v);
    m_i = $signed(im_v);
    m   = (k % 2 == 1) ? (m_i - r) : (r + m_i);
    e.llr_a = sat_llr(m, 10, 8);
    e.llr_b = sat_llr(m, 0, 8);
    e.bit_v = (m < 0) ? 1 : 0;
    e.index = k;
    e.sop   = sop;
    e.last  = last;
    mdl_idx = last ? 0 : (k + 1) % 65536;
    return e;
  endfunction

  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(0, 1) == 1);
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks backpressure, stability while stalled, and drains the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      chk("o_ready_a", o_ready_a, (in_flight < 2 || i_ready) ? 1 : 0);
      chk("o_ready_b", o_ready_b, (in_flight < 2 || i_ready) ? 1 : 0);
      if (stalled && !o_valid_a) chk("hold_valid", 0, 1);
      if (o_valid_a) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          chk("valid_b", o_valid_b, 1);
          chk("llr_a", $signed(o_llr_a), q[0].llr_a);
          chk("llr_b", $signed(o_llr_b), q[0].llr_b);
          chk("bit_a", o_bit_a, q[0].bit_v);
          chk("bit_b", o_bit_b, q[0].bit_v);
          chk("index", o_index_a, q[0].index);
          chk("sop", o_sop_a, q[0].sop);
          chk("last", o_last_a, q[0].last);
          if (i_ready) begin
            void'(q.pop_front());
            in_flight--;
            stalled = 0;
          end else begin
            stalled = 1;
          end
        end
      end else begin
        stalled = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [15:0] re_v, input logic [15:0] im_v,
                      input bit sop, input bit last);
    bit accepted;
    exp_t e;
    accepted = 0;
    i_valid = 1'b1; re = re_v; im = im_v; i_sop = sop; i_last = last;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      #1;
      if (o_ready_a) begin
        e = model(re_v, im_v, sop, last);
        q.push_back(e);
        in_flight++;
        acc_cyc = cyc;
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0; i_sop = 1'b0; i_last = 1'b0;
    if (!accepted) chk("accept_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid_a", o_valid_a, 0); chk("rst_llr_a", o_llr_a, 0);
    chk("rst_bit_a", o_bit_a, 0);     chk("rst_index_a", o_index_a, 0);
    chk("rst_sop_a", o_sop_a, 0);     chk("rst_last_a", o_last_a, 0);
    chk("rst_valid_b", o_valid_b, 0); chk("rst_llr_b", o_llr_b, 0);
    chk("rst_index_b", o_index_b, 0); chk("rst_last_b", o_last_b, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_remaining", q.size(), 0);
  endtask

  logic [15:0] ext_vals [0:5];

  initial begin
    int got;
    ext_vals[0] = 16'h7FFF; ext_vals[1] = 16'h8000; ext_vals[2] = 16'h0000;
    ext_vals[3] = 16'h5A82; ext_vals[4] = 16'hA57E; ext_vals[5] = 16'hFFFF;
    rst_n = 1'b0; i_valid = 1'b0; i_sop = 1'b0; i_last = 1'b0; re = '0; im = '0;
    #12;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    chk("ready_after_release", o_ready_a, 1);

    // k=0 reference point and its 2-clock latency
    send(16'h5A82, 16'h5A82, 1, 0);
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (o_valid_a) got = 1;
    end
    chk("latency", got ? (cyc - acc_cyc) : -1, 2);
    @(posedge clk); #1;

    // odd-index derotation in both directions
    send(16'h0000, 16'h0000, 1, 0);
    send(16'hA57E, 16'h5A82, 0, 1);
    send(16'h1111, 16'h2222, 1, 0);
    send(16'h5A82, 16'hA57E, 0, 1);
    // saturation extremes and the m == 0 tie
    send(16'h7FFF, 16'h7FFF, 1, 1);
    send(16'h8000, 16'h8000, 1, 1);
    send(16'h1000, 16'hF000, 1, 1);
    // block of 3, next block without sop, then a single-symbol block
    send(16'h0100, 16'h0200, 1, 0);
    send(16'h0300, 16'hFC00, 0, 0);
    send(16'hF000, 16'h0123, 0, 1);
    send(16'h2000, 16'h2000, 0, 0);
    send(16'hE000, 16'h1000, 0, 0);
    send(16'h4000, 16'hC000, 0, 1);
    send(16'h3000, 16'h3000, 1, 1);
    drain();

    // random stream with random backpressure
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [15:0] rv, iv;
      rv = ($urandom_range(0, 4) == 0) ? ext_vals[$urandom_range(0, 5)] : 16'($urandom);
      iv = ($urandom_range(0, 4) == 0) ? ext_vals[$urandom_range(0, 5)] : 16'($urandom);
      send(rv, iv, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    ready_mode = 0;
    drain();

    // reset with two symbols held mid-block
    ready_mode = 2;
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 1, 0);
    send(16'h5555, 16'h2222, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_ready_low", o_ready_a, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    in_flight = 0;
    mdl_idx = 0;
    ready_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", o_ready_a, 1);
    chk("no_stale_valid", o_valid_a, 0);
    send(16'h0800, 16'hF400, 0, 0);
    send(16'h0800, 16'hF400, 0, 1);

    ready_mode = 1;
    for (int n = 0; n < 60; n++) begin
      send(16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
